controller_cmd_queue: RTL and testbench

CONTROLLER_CMD_QUEUE -- requirements
Module: controller_cmd_queue

---
 rtl/controller_cmd_queue.sv | 141 ++++++++++++++
 tb/tb_controller_cmd_queue.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/controller_cmd_queue.sv
// Command queue between the input decoder and the controller FSM.
// Circular buffer with occupancy count, sticky overflow flag and last-popped command register.
module controller_cmd_queue #(
  parameter int               CMD_W    = 5,
  parameter int               DEPTH    = 4,
  parameter int               PTR_W    = 2,
  parameter logic [CMD_W-1:0] IDLE_CMD = '0
) (
  input  logic             clk,
  input  logic             Reset,
  input  logic [CMD_W-1:0] in_cmd,
  input  logic             in_valid,
  input  logic             accept_en,
  input  logic             pop,
  input  logic             flush,
  output logic [CMD_W-1:0] cmd_head,
  output logic             cmd_valid,
  output logic [CMD_W-1:0] last_cmd,
  output logic [PTR_W:0]   count,
  output logic             full,
  output logic             overflow
);

  localparam logic [PTR_W:0]   CNT_ZERO = (PTR_W+1)'(0);
  localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W+1)'(1);
  localparam logic [PTR_W:0]   CNT_FULL = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W-1:0] PTR_ZERO = PTR_W'(0);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

  logic [CMD_W-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [PTR_W:0]   count_r;
  logic             overflow_r;
  logic [CMD_W-1:0] last_cmd_r;

  logic             valid_s;
  logic             full_s;
  logic [CMD_W-1:0] head_s;
  logic             push_try_s;
  logic             pop_eff_s;
  logic             push_s;
  logic             drop_s;
  logic [PTR_W-1:0] wr_ptr_nxt_s;
  logic [PTR_W-1:0] rd_ptr_nxt_s;
  logic [PTR_W:0]   count_nxt_s;
  logic             overflow_nxt_s;
  logic [CMD_W-1:0] last_cmd_nxt_s;

  // Status decode from registered state only; stale storage is masked when empty
  always_comb begin
    valid_s = (count_r != CNT_ZERO);
    full_s  = (count_r == CNT_FULL);
    if (valid_s) begin
      head_s = mem_r[rd_ptr_r];
    end else begin
      head_s = IDLE_CMD;
    end
  end

  // Push/pop qualification; a pop frees the slot the same-cycle push needs when full
  always_comb begin
    push_try_s = in_valid & accept_en & ~flush;
    pop_eff_s  = pop & valid_s & ~flush;
    push_s     = push_try_s & (~full_s | pop_eff_s);
    drop_s     = push_try_s & full_s & ~pop_eff_s;
  end

  // Next-state computation; flush overrides push and pop but keeps last_cmd
  always_comb begin
    wr_ptr_nxt_s   = wr_ptr_r;
    rd_ptr_nxt_s   = rd_ptr_r;
    count_nxt_s    = count_r;
    overflow_nxt_s = overflow_r;
    last_cmd_nxt_s = last_cmd_r;
    if (flush) begin
      wr_ptr_nxt_s   = PTR_ZERO;
      rd_ptr_nxt_s   = PTR_ZERO;
      count_nxt_s    = CNT_ZERO;
      overflow_nxt_s = 1'b0;
    end else begin
      if (push_s) begin
        wr_ptr_nxt_s = wr_ptr_r + PTR_ONE;
      end else begin
        wr_ptr_nxt_s = wr_ptr_r;
      end
      if (pop_eff_s) begin
        rd_ptr_nxt_s   = rd_ptr_r + PTR_ONE;
        last_cmd_nxt_s = head_s;
      end else begin
        rd_ptr_nxt_s   = rd_ptr_r;
        last_cmd_nxt_s = last_cmd_r;
      end
      case ({push_s, pop_eff_s})
        2'b10:   count_nxt_s = count_r + CNT_ONE;
        2'b01:   count_nxt_s = count_r - CNT_ONE;
        default: count_nxt_s = count_r;
      endcase
      if (drop_s) begin
        overflow_nxt_s = 1'b1;
      end else begin
        overflow_nxt_s = overflow_r;
      end
    end
  end

  // Control state register with synchronous reset
  always_ff @(posedge clk) begin
    if (Reset) begin
      wr_ptr_r   <= PTR_ZERO;
      rd_ptr_r   <= PTR_ZERO;
      count_r    <= CNT_ZERO;
      overflow_r <= 1'b0;
      last_cmd_r <= IDLE_CMD;
    end else begin
      wr_ptr_r   <= wr_ptr_nxt_s;
      rd_ptr_r   <= rd_ptr_nxt_s;
      count_r    <= count_nxt_s;
      overflow_r <= overflow_nxt_s;
      last_cmd_r <= last_cmd_nxt_s;
    end
  end

  // Storage write; contents are don't-care while not counted, so no reset
  always_ff @(posedge clk) begin
    if (push_s && !Reset) begin
      mem_r[wr_ptr_r] <= in_cmd;
    end
  end

  // Output drive
  always_comb begin
    cmd_head  = head_s;
    cmd_valid = valid_s;
    last_cmd  = last_cmd_r;
    count     = count_r;
    full      = full_s;
    overflow  = overflow_r;
  end

endmodule

// File: tb/tb_controller_cmd_queue.sv
// Self-checking bench for controller_cmd_queue: queue-based reference model
// compared every cycle, plus directed scenarios with hand-computed expectations.
module tb_controller_cmd_queue;

  logic       clk = 1'b0;
  logic       Reset;
  logic [4:0] in_cmd;
  logic       in_valid;
  logic       accept_en;
  logic       pop;
  logic       flush;
  logic [4:0] cmd_head;
  logic       cmd_valid;
  logic [4:0] last_cmd;
  logic [2:0] count;
  logic       full;
  logic       overflow;

  int tests = 0;
  int fails = 0;

  controller_cmd_queue #(.CMD_W(5), .DEPTH(4), .PTR_W(2), .IDLE_CMD(5'h00)) dut (
    .clk(clk), .Reset(Reset), .in_cmd(in_cmd), .in_valid(in_valid),
    .accept_en(accept_en), .pop(pop), .flush(flush), .cmd_head(cmd_head),
    .cmd_valid(cmd_valid), .last_cmd(last_cmd), .count(count), .full(full),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  // reference model state
  logic [4:0] mq[$];
  logic [4:0] m_last;
  logic       m_ovf;
  bit         m_ok = 1'b0;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // model update on the same edge the DUT samples
  always @(posedge clk) begin
    int  sz;
    bit  pe;
    bit  tryp;
    if (Reset) begin
      mq.delete();
      m_ovf  = 1'b0;
      m_last = 5'h00;
      m_ok   = 1'b1;
    end else if (flush) begin
      mq.delete();
      m_ovf = 1'b0;
    end else begin
      sz   = mq.size();
      pe   = pop && (sz > 0);
      tryp = in_valid && accept_en;
      if (pe) begin
        m_last = mq.pop_front();
      end
      if (tryp && (sz < 4 || pe)) mq.push_back(in_cmd);
      if (tryp && sz == 4 && !pe) m_ovf = 1'b1;
    end
  end

  // every-cycle comparison away from the active edge
  always @(negedge clk) begin
    if (m_ok) begin
      chk("m_count", {5'd0, count}, 8'(mq.size()));
      chk("m_valid", {7'd0, cmd_valid}, {7'd0, (mq.size() != 0)});
      chk("m_full", {7'd0, full}, {7'd0, (mq.size() == 4)});
      chk("m_head", {3'd0, cmd_head}, {3'd0, (mq.size() != 0) ? mq[0] : 5'h00});
      chk("m_last", {3'd0, last_cmd}, {3'd0, m_last});
      chk("m_ovf", {7'd0, overflow}, {7'd0, m_ovf});
    end
  end

  task automatic step(input logic r, input logic v, input logic a, input logic [4:0] c,
                      input logic p, input logic f);
    Reset = r; in_valid = v; accept_en = a; in_cmd = c; pop = p; flush = f;
    @(posedge clk);
    #1;
    Reset = 1'b0; in_valid = 1'b0; pop = 1'b0; flush = 1'b0; accept_en = 1'b0; in_cmd = 5'h00;
  endtask

  task automatic push(input logic [4:0] c);
    step(1'b0, 1'b1, 1'b1, c, 1'b0, 1'b0);
  endtask

  task automatic do_pop();
    step(1'b0, 1'b0, 1'b0, 5'h00, 1'b1, 1'b0);
  endtask

  initial begin
    Reset = 1'b1; in_valid = 1'b0; accept_en = 1'b0; in_cmd = 5'h00; pop = 1'b0; flush = 1'b0;
    step(1'b1, 1'b0, 1'b0, 5'h00, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1, 5'h1F, 1'b1, 1'b0);
    chk("rst_count", {5'd0, count}, 8'h00);
    chk("rst_head", {3'd0, cmd_head}, 8'h00);
    chk("rst_last", {3'd0, last_cmd}, 8'h00);

    // two pushes, then drain with an extra pop on empty
    push(5'h03);
    chk("p1_head", {3'd0, cmd_head}, 8'h03);
    chk("p1_count", {5'd0, count}, 8'h01);
    push(5'h07);
    chk("p2_count", {5'd0, count}, 8'h02);
    chk("p2_head", {3'd0, cmd_head}, 8'h03);
    do_pop();
    chk("pop1_last", {3'd0, last_cmd}, 8'h03);
    do_pop();
    chk("pop2_last", {3'd0, last_cmd}, 8'h07);
    chk("pop2_valid", {7'd0, cmd_valid}, 8'h00);
    chk("pop2_head", {3'd0, cmd_head}, 8'h00);
    do_pop();
    chk("pop3_last", {3'd0, last_cmd}, 8'h07);
    chk("pop3_count", {5'd0, count}, 8'h00);

    // push onto empty with pop asserted: pop ignored
    step(1'b0, 1'b1, 1'b1, 5'h01, 1'b1, 1'b0);
    chk("pe_count", {5'd0, count}, 8'h01);
    chk("pe_last", {3'd0, last_cmd}, 8'h07);
    for (int i = 2; i <= 4; i++) push(5'(i));
    chk("fill_full", {7'd0, full}, 8'h01);
    push(5'h05);
    chk("ovf_flag", {7'd0, overflow}, 8'h01);
    chk("ovf_count", {5'd0, count}, 8'h04);
    chk("ovf_head", {3'd0, cmd_head}, 8'h01);
    step(1'b0, 1'b1, 1'b1, 5'h06, 1'b1, 1'b0);
    chk("pp_last", {3'd0, last_cmd}, 8'h01);
    chk("pp_count", {5'd0, count}, 8'h04);
    chk("pp_ovf", {7'd0, overflow}, 8'h01);
    do_pop();
    chk("q3_last", {3'd0, last_cmd}, 8'h02);
    chk("q3_head", {3'd0, cmd_head}, 8'h03);

    // flush with 3 entries and overflow set, same-cycle push 0A
    step(1'b0, 1'b1, 1'b1, 5'h0A, 1'b1, 1'b1);
    chk("fl_count", {5'd0, count}, 8'h00);
    chk("fl_ovf", {7'd0, overflow}, 8'h00);
    chk("fl_valid", {7'd0, cmd_valid}, 8'h00);
    chk("fl_last", {3'd0, last_cmd}, 8'h02);

    // steady count 2 across 9 entries, wrapping pointers
    push(5'h10);
    push(5'h11);
    for (int i = 0; i < 9; i++) begin
      step(1'b0, 1'b1, 1'b1, 5'(8'h12 + i), 1'b1, 1'b0);
      chk("wrap_last", {3'd0, last_cmd}, 8'(8'h10 + i));
      chk("wrap_count", {5'd0, count}, 8'h02);
    end
    do_pop();
    chk("wrap_tail1", {3'd0, last_cmd}, 8'h19);
    do_pop();
    chk("wrap_tail2", {3'd0, last_cmd}, 8'h1A);

    // in_valid without accept_en is ignored
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 5'h0C, 1'b0, 1'b0);
    chk("noacc_count", {5'd0, count}, 8'h00);
    chk("noacc_ovf", {7'd0, overflow}, 8'h00);

    // reset mid-stream with 2 entries, overriding push/pop/flush
    push(5'h0D);
    push(5'h0E);
    step(1'b1, 1'b1, 1'b1, 5'h0F, 1'b1, 1'b1);
    chk("mrst_count", {5'd0, count}, 8'h00);
    chk("mrst_valid", {7'd0, cmd_valid}, 8'h00);
    chk("mrst_full", {7'd0, full}, 8'h00);
    chk("mrst_head", {3'd0, cmd_head}, 8'h00);
    chk("mrst_last", {3'd0, last_cmd}, 8'h00);
    push(5'h15);
    chk("post_head", {3'd0, cmd_head}, 8'h15);
    chk("post_count", {5'd0, count}, 8'h01);

    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
